// File: rtl/fetch_unit.sv
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction-fetch stage feeding the IF/ID register over a
//             req/gnt/rvalid memory handshake, with stall and redirect.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0033
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_IF,
  output logic [31:0] pc_IF,
  output logic        valid_IF
);

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_WAIT    = 2'd1,
    S_HOLD    = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic        valid_q, valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;

  logic        slot_free;
  logic [31:0] pc_inc;
  logic [31:0] redirect_tgt;

  assign slot_free    = !valid_q || !stall;
  assign pc_inc       = pc_q + 32'd4;
  assign redirect_tgt = redirect_pc & ~32'h0000_0003;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    out_pc_d     = out_pc_q;
    valid_d      = valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;

    // A consumed slot empties unless one of the refill paths below reloads it.
    if (valid_q && !stall) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end

    case (state_q)
      S_REQ: begin
        if (imem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          pc_d = pc_inc;
          if (slot_free) begin
            valid_d  = 1'b1;
            instr_d  = imem_rdata;
            out_pc_d = pc_q;
            state_d  = S_REQ;
          end else begin
            skid_instr_d = imem_rdata;
            skid_pc_d    = pc_q;
            state_d      = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (slot_free) begin
          valid_d      = 1'b1;
          instr_d      = skid_instr_q;
          out_pc_d     = skid_pc_q;
          skid_instr_d = 32'd0;
          skid_pc_d    = 32'd0;
          state_d      = S_REQ;
        end
      end
      S_DISCARD: begin
        if (imem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase

    // Redirect wins over everything; a granted old-PC request must be drained.
    if (redirect) begin
      pc_d         = redirect_tgt;
      valid_d      = 1'b0;
      instr_d      = NOP_INSTR;
      skid_instr_d = 32'd0;
      skid_pc_d    = 32'd0;
      case (state_q)
        S_REQ:     state_d = imem_gnt ? S_DISCARD : S_REQ;
        S_WAIT:    state_d = imem_rvalid ? S_REQ : S_DISCARD;
        S_DISCARD: state_d = imem_rvalid ? S_REQ : S_DISCARD;
        default:   state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      instr_q      <= NOP_INSTR;
      out_pc_q     <= 32'd0;
      valid_q      <= 1'b0;
      skid_instr_q <= 32'd0;
      skid_pc_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      out_pc_q     <= out_pc_d;
      valid_q      <= valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign imem_req       = (state_q == S_REQ) && !rst;
  assign imem_addr      = pc_q;
  assign instruction_IF = instr_q;
  assign pc_IF          = out_pc_q;
  assign valid_IF       = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Randomized and directed self-checking bench for fetch_unit.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0033;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] instruction_IF;
  logic [31:0] pc_IF;
  logic        valid_IF;

  fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instruction_IF (instruction_IF),
    .pc_IF          (pc_IF),
    .valid_IF       (valid_IF)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Memory model: one outstanding read, data = addr ^ KEY.
  int unsigned gnt_pct = 100;
  int unsigned lat_min = 1;
  int unsigned lat_max = 1;
  bit          pend = 1'b0;
  int unsigned cnt = 0;
  logic [31:0] pend_addr = 32'd0;
  int          n_rvalid = 0;

  // Architectural reference: program-order fetch and delivery addresses.
  logic [31:0] exp_fetch = RESET_PC;
  logic [31:0] exp_out_pc = RESET_PC;
  logic [31:0] grant_q[$];
  logic [31:0] out_q[$];
  int          n_consumed = 0;

  bit          prev_hold = 1'b0;
  bit          prev_redirect = 1'b0;
  bit          prev_rst = 1'b0;
  logic [31:0] prev_instr = 32'd0;
  logic [31:0] prev_pc = 32'd0;

  // One clock cycle: drive memory, check the slot/handshake rules, advance.
  task automatic tick();
    logic        granted;
    logic [31:0] gaddr;
    logic        rv;
    logic [31:0] tgt;
    imem_rvalid = pend && (cnt == 0);
    imem_rdata  = imem_rvalid ? (pend_addr ^ KEY) : $urandom();
    imem_gnt    = ($urandom_range(99) < gnt_pct);
    #1;
    tgt = {redirect_pc[31:2], 2'b00};
    if (rst) begin
      checks++;
      if (imem_req !== 1'b0) begin
        failures++; $display("FAIL req_in_rst: got %b want 0", imem_req);
      end
    end else begin
      checks++;
      if (!valid_IF && instruction_IF !== NOP) begin
        failures++; $display("FAIL idle_nop: got %h want %h", instruction_IF, NOP);
      end
      if (prev_hold) begin
        checks++;
        if (valid_IF !== 1'b1 || instruction_IF !== prev_instr || pc_IF !== prev_pc) begin
          failures++;
          $display("FAIL hold: got v=%b i=%h pc=%h want v=1 i=%h pc=%h",
                   valid_IF, instruction_IF, pc_IF, prev_instr, prev_pc);
        end
      end
      if (prev_redirect) begin
        checks++;
        if (valid_IF !== 1'b0) begin
          failures++; $display("FAIL redirect_flush: got valid=%b want 0", valid_IF);
        end
      end
      if (prev_rst) begin
        checks++;
        if (valid_IF !== 1'b0 || instruction_IF !== NOP || pc_IF !== 32'd0) begin
          failures++;
          $display("FAIL post_reset: got v=%b i=%h pc=%h want v=0 i=%h pc=0",
                   valid_IF, instruction_IF, pc_IF, NOP);
        end
      end
      if (imem_req === 1'b1) begin
        checks++;
        if (pend) begin
          failures++; $display("FAIL outstanding: got req=1 with pending read want req=0");
        end
        checks++;
        if (imem_addr !== exp_fetch) begin
          failures++; $display("FAIL fetch_addr: got %h want %h", imem_addr, exp_fetch);
        end
        if (imem_gnt) begin
          grant_q.push_back(imem_addr);
          exp_fetch = exp_fetch + 32'd4;
        end
      end
      if (valid_IF === 1'b1 && !stall) begin
        checks++;
        if (pc_IF !== exp_out_pc || instruction_IF !== (exp_out_pc ^ KEY)) begin
          failures++;
          $display("FAIL deliver: got pc=%h i=%h want pc=%h i=%h",
                   pc_IF, instruction_IF, exp_out_pc, exp_out_pc ^ KEY);
        end
        out_q.push_back(pc_IF);
        exp_out_pc = exp_out_pc + 32'd4;
        n_consumed++;
      end
      if (redirect) begin
        exp_fetch  = tgt;
        exp_out_pc = tgt;
      end
    end
    if (rst) begin
      exp_fetch  = RESET_PC;
      exp_out_pc = RESET_PC;
    end
    prev_hold     = !rst && !redirect && (valid_IF === 1'b1) && stall;
    prev_instr    = instruction_IF;
    prev_pc       = pc_IF;
    prev_redirect = redirect && !rst;
    prev_rst      = rst;
    granted = (imem_req === 1'b1) && imem_gnt;
    gaddr   = imem_addr;
    rv      = imem_rvalid;
    @(posedge clk);
    @(negedge clk);
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (rv) begin
        pend = 1'b0;
        n_rvalid++;
      end else if (pend && cnt > 0) begin
        cnt = cnt - 1;
      end
      if (granted) begin
        pend      = 1'b1;
        pend_addr = gaddr;
        cnt       = $urandom_range(lat_max, lat_min) - 1;
      end
    end
  endtask

  task automatic do_reset();
    stall = 1'b0; redirect = 1'b0; rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    grant_q.delete(); out_q.delete();
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (valid_IF !== 1'b1 && n < 30) begin tick(); n++; end
    if (valid_IF !== 1'b1) begin
      checks++; failures++; $display("FAIL %s_timeout: got no valid want valid_IF=1", name);
    end
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (imem_req !== 1'b1 && n < 30) begin tick(); n++; end
    if (imem_req !== 1'b1) begin
      checks++; failures++; $display("FAIL %s_timeout: got no req want imem_req=1", name);
    end
  endtask

  task automatic test_reset();
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (imem_req !== 1'b0) begin
      failures++; $display("FAIL reset_req: got %b want 0", imem_req);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (valid_IF !== 1'b0 || instruction_IF !== NOP || pc_IF !== 32'd0) begin
      failures++;
      $display("FAIL reset_slot: got v=%b i=%h pc=%h want v=0 i=%h pc=0", valid_IF, instruction_IF, pc_IF, NOP);
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      failures++; $display("FAIL reset_fetch: got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_sequential();
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    do_reset();
    repeat (12) tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (grant_q.size() <= i || grant_q[i] !== 32'(4 * i)) begin
        failures++;
        $display("FAIL seq_addr%0d: got %h want %h", i, (grant_q.size() > i) ? grant_q[i] : 32'hxxxx_xxxx, 32'(4 * i));
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_q.size() <= i || out_q[i] !== 32'(4 * i)) begin
        failures++;
        $display("FAIL seq_pc%0d: got %h want %h", i, (out_q.size() > i) ? out_q[i] : 32'hxxxx_xxxx, 32'(4 * i));
      end
    end
  endtask

  task automatic test_stall_skid();
    int g0;
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    do_reset();
    wait_valid("skid_first");
    checks++;
    if (pc_IF !== 32'd0) begin
      failures++; $display("FAIL skid_first_pc: got %h want 0", pc_IF);
    end
    stall = 1'b1;
    g0 = grant_q.size();
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (valid_IF !== 1'b1 || pc_IF !== 32'd0 || imem_req !== 1'b0) begin
        failures++;
        $display("FAIL skid_hold%0d: got v=%b pc=%h req=%b want v=1 pc=0 req=0", i, valid_IF, pc_IF, imem_req);
      end
    end
    checks++;
    if (grant_q.size() != g0 + 1 || grant_q[grant_q.size() - 1] !== 32'h4) begin
      failures++; $display("FAIL skid_grants: got %0d grants want %0d ending at 4", grant_q.size() - g0, 1);
    end
    stall = 1'b0;
    tick();
    checks++;
    if (valid_IF !== 1'b1 || pc_IF !== 32'h4 || instruction_IF !== (32'h4 ^ KEY)) begin
      failures++;
      $display("FAIL skid_release: got v=%b pc=%h i=%h want v=1 pc=4 i=%h", valid_IF, pc_IF, instruction_IF, 32'h4 ^ KEY);
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      failures++; $display("FAIL skid_next_req: got req=%b addr=%h want req=1 addr=8", imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_wait();
    int nrv;
    gnt_pct = 100; lat_min = 3; lat_max = 3;
    do_reset();
    tick();
    checks++;
    if (imem_req !== 1'b0) begin
      failures++; $display("FAIL rw_in_wait: got req=%b want 0", imem_req);
    end
    nrv = n_rvalid;
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    checks++;
    if (valid_IF !== 1'b0) begin
      failures++; $display("FAIL rw_valid: got %b want 0", valid_IF);
    end
    wait_req("rw_req");
    checks++;
    if (imem_addr !== 32'h100 || n_rvalid != nrv + 1) begin
      failures++; $display("FAIL rw_req_addr: got addr=%h drained=%0d want addr=100 drained=1", imem_addr, n_rvalid - nrv);
    end
    wait_valid("rw_valid");
    checks++;
    if (pc_IF !== 32'h100 || instruction_IF !== (32'h100 ^ KEY)) begin
      failures++; $display("FAIL rw_out: got pc=%h i=%h want pc=100 i=%h", pc_IF, instruction_IF, 32'h100 ^ KEY);
    end
  endtask

  task automatic test_redirect_gnt();
    int nrv;
    gnt_pct = 100; lat_min = 2; lat_max = 2;
    do_reset();
    nrv = n_rvalid;
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    checks++;
    if (imem_req !== 1'b0 || valid_IF !== 1'b0) begin
      failures++; $display("FAIL rg_discard: got req=%b v=%b want req=0 v=0", imem_req, valid_IF);
    end
    wait_req("rg_req");
    checks++;
    if (imem_addr !== 32'h200 || n_rvalid != nrv + 1) begin
      failures++; $display("FAIL rg_req_addr: got addr=%h drained=%0d want addr=200 drained=1", imem_addr, n_rvalid - nrv);
    end
    wait_valid("rg_valid");
    checks++;
    if (pc_IF !== 32'h200) begin
      failures++; $display("FAIL rg_out: got pc=%h want 200", pc_IF);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    gnt_pct = 0;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    grant_q.delete(); out_q.delete();
    repeat (10) tick();
    checks++;
    if (grant_q.size() < 2 || grant_q[0] !== 32'hFFFF_FFFC || grant_q[1] !== 32'h0) begin
      failures++; $display("FAIL wrap_addr: got %0d grants want FFFFFFFC then 00000000", grant_q.size());
    end
    checks++;
    if (out_q.size() < 2 || out_q[0] !== 32'hFFFF_FFFC || out_q[1] !== 32'h0) begin
      failures++; $display("FAIL wrap_pc: got %0d deliveries want FFFFFFFC then 00000000", out_q.size());
    end
  endtask

  task automatic test_reset_midwait();
    gnt_pct = 100; lat_min = 4; lat_max = 4;
    do_reset();
    stall = 1'b1;
    wait_valid("rm_valid");
    tick();
    checks++;
    if (valid_IF !== 1'b1 || imem_req !== 1'b0) begin
      failures++; $display("FAIL rm_setup: got v=%b req=%b want v=1 req=0", valid_IF, imem_req);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (valid_IF !== 1'b0 || instruction_IF !== NOP || pc_IF !== 32'd0 || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL rm_reset: got v=%b i=%h pc=%h req=%b want v=0 i=%h pc=0 req=0", valid_IF, instruction_IF, pc_IF, imem_req, NOP);
    end
    rst = 1'b0; stall = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      failures++; $display("FAIL rm_restart: got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_random();
    int start;
    do_reset();
    start = n_consumed;
    for (int seg = 0; seg < 8; seg++) begin
      gnt_pct = $urandom_range(100, 30);
      lat_min = 1;
      lat_max = $urandom_range(4, 1);
      repeat (250) begin
        stall       = ($urandom_range(99) < 30);
        redirect    = ($urandom_range(99) < 3);
        redirect_pc = $urandom();
        tick();
      end
    end
    stall = 1'b0; redirect = 1'b0;
    checks++;
    if (n_consumed - start < 50) begin
      failures++; $display("FAIL random_progress: got %0d deliveries want >= 50", n_consumed - start);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_sequential();
    test_stall_skid();
    test_redirect_wait();
    test_redirect_gnt();
    test_wrap();
    test_reset_midwait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
